// File: rtl/cam_read_fmt.sv
// cam_read_fmt: camera byte-pair capture front end.
// Pairs RGB565 camera bytes into pixels, converts them to RGB332/RGB444/RGB565,
// clips to an IMG_W x IMG_H window and writes them to a frame-buffer port.
// Also tracks frame sync, counts captured frames and flags malformed lines.
// Optional build macro: CAM_READ_FMT_TESTPAT_EN adds a test_en input that
// replaces the converted pixel with a {row, col} pattern word.
module cam_read_fmt #(
  parameter int AW    = 15,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int CW    = 8
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    fmt,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
`ifdef CAM_READ_FMT_TESTPAT_EN
  input  logic          test_en,
`endif
  output logic [AW-1:0] mem_px_addr,
  output logic [15:0]   mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          line_err,
  output logic          busy
);

  typedef enum logic [1:0] {WAIT_VS, F_BLANK, F_ACTIVE} state_t;

  localparam logic [CW-1:0] W_C     = CW'(IMG_W);
  localparam logic [CW-1:0] H_C     = CW'(IMG_H);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic          vsync_q;
  logic          in_line_q, in_line_d;
  logic          phase_q, phase_d;
  logic [7:0]    b1_q, b1_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [15:0]   pixel;

`ifdef CAM_READ_FMT_TESTPAT_EN
  logic [15:0]   pat;
  assign pat = {8'(row_q), 8'(col_q)};
`endif

  // Pixel formation: b1 is the latched first byte, px_data is b2 this cycle.
  always_comb begin
    pixel = {8'b0, b1_q[7:5], b1_q[2:0], px_data[4:3]};
    case (fmt)
      2'd1:    pixel = {4'b0, b1_q[7:4], b1_q[2:0], px_data[7], px_data[4:1]};
      2'd2:    pixel = {b1_q, px_data};
      default: pixel = {8'b0, b1_q[7:5], b1_q[2:0], px_data[4:3]};
    endcase
`ifdef CAM_READ_FMT_TESTPAT_EN
    if (test_en) begin
      case (fmt)
        2'd1:    pixel = {4'b0, pat[11:0]};
        2'd2:    pixel = pat;
        default: pixel = {8'b0, pat[7:0]};
      endcase
    end
`endif
  end

  // Next-state logic: frame FSM, byte pairing, clipping, line/frame bookkeeping.
  always_comb begin
    state_d   = state_q;
    in_line_d = in_line_q;
    phase_d   = phase_q;
    b1_d      = b1_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      WAIT_VS: begin
        // Only a frame whose start we fully observed is taken after reset.
        if (vsync) state_d = F_BLANK;
      end
      F_BLANK: begin
        if (vsync_q && !vsync && en) begin
          state_d   = F_ACTIVE;
          base_d    = '0;
          row_d     = '0;
          col_d     = '0;
          phase_d   = 1'b0;
          in_line_d = 1'b0;
        end
      end
      F_ACTIVE: begin
        if (vsync) begin
          // Frame end; a half-finished line is dropped without writing.
          state_d   = F_BLANK;
          done_d    = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          if (row_q < H_C) err_d = 1'b1;
          in_line_d = 1'b0;
          phase_d   = 1'b0;
          col_d     = '0;
        end else if (href) begin
          in_line_d = 1'b1;
          phase_d   = ~phase_q;
          if (!phase_q) begin
            b1_d = px_data;
          end else begin
            if (col_q < W_C && row_q < H_C) begin
              wr_d   = 1'b1;
              data_d = pixel;
              addr_d = base_q + AW'(col_q);
            end
            if (col_q != CNT_MAX) col_d = col_q + 1'b1;
          end
        end else if (in_line_q) begin
          // Line end: odd byte count or a short line is an error.
          in_line_d = 1'b0;
          if (phase_q || col_q < W_C) err_d = 1'b1;
          phase_d = 1'b0;
          col_d   = '0;
          if (row_q != CNT_MAX) row_d = row_q + 1'b1;
          if (row_q < H_C) base_d = base_q + AW'(IMG_W);
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_VS;
      vsync_q   <= 1'b0;
      in_line_q <= 1'b0;
      phase_q   <= 1'b0;
      b1_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync;
      in_line_q <= in_line_d;
      phase_q   <= phase_d;
      b1_q      <= b1_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign frame_done  = done_q;
  assign frame_cnt   = cnt_q;
  assign line_err    = err_q;
  assign busy        = (state_q == F_ACTIVE);

endmodule
